// File: rtl/self_trig_pkg.sv
// Shared types and helpers for the self-trigger arbiter.
// FSM states, record layout and a constant-function log2.
package self_trig_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam int TS_W_DEF = 42;
   localparam int CH_W_DEF = 2;

   typedef struct packed {
      logic [CH_W_DEF-1:0] chan;
      logic [TS_W_DEF-1:0] ts;
   } rec_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/self_trig_arbiter_if.sv
// Trigger-record output stream (valid/ready) between the arbiter and the readout link.
interface self_trig_arbiter_if
   import self_trig_pkg::*;
#(
   parameter int TS_W = TS_W_DEF,
   parameter int CH_W = CH_W_DEF
);
   logic            out_valid;
   logic            out_ready;
   logic [CH_W-1:0] out_chan;
   logic [TS_W-1:0] out_ts;

   modport master (output out_valid, output out_chan, output out_ts, input out_ready);
   modport slave  (input out_valid, input out_chan, input out_ts, output out_ready);
endinterface

// File: rtl/self_trig_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches upward with wrap from the channel after the last grant.
// ptr_reg holds that search start, so after reset channel 0 has first priority.
module rr_arbiter #(
   parameter int NCH   = 4,
   parameter int IDX_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NCH-1:0]   req,
   input  logic             advance,
   output logic [NCH-1:0]   grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             any
);
   logic [IDX_W-1:0] ptr_reg;

   // Descending scan: the last hit written is the smallest offset from ptr_reg.
   always_comb begin
      int c;
      grant_idx = '0;
      any       = 1'b0;
      c         = 0;
      for (int k = NCH - 1; k >= 0; k--) begin
         c = int'(ptr_reg) + k;
         if (c >= NCH) c = c - NCH;
         if (req[IDX_W'(c)]) begin
            grant_idx = IDX_W'(c);
            any       = 1'b1;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_onehot
         assign grant[gi] = any && (grant_idx == IDX_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg <= '0;
      end else if (advance && any) begin
         ptr_reg <= (grant_idx == IDX_W'(NCH - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
   end
endmodule

// File: rtl/self_trig_arbiter.sv
// Self-trigger controller: arming FSM, per-channel edge capture, round-robin readout.
// Optional macro SELF_TRIG_PRESCALE_EN adds a per-channel 1-of-(prescale+1) edge prescaler.
module self_trig_arbiter
   import self_trig_pkg::*;
#(
   parameter int NCH         = 4,
   parameter int TS_W        = TS_W_DEF,
   parameter int CH_W        = CH_W_DEF,
   parameter int ARM_TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                run,
   input  logic [NCH-1:0]      ch_mask,
   output logic [NCH-1:0]      ch_enable,
   input  logic [NCH-1:0]      ch_ready,
   input  logic [NCH-1:0]      ch_trig,
   input  logic [NCH*TS_W-1:0] ch_ts,
`ifdef SELF_TRIG_PRESCALE_EN
   input  logic [7:0]          prescale,
`endif
   self_trig_arbiter_if.master stream,
   output logic                armed,
   output logic                arm_err,
   output logic [NCH-1:0]      ovf_flags,
   output logic [15:0]         ovf_cnt
);
   localparam int TMR_W = clog2(ARM_TIMEOUT + 1);

   state_t           state_reg;
   logic [NCH-1:0]   mask_reg;
   logic [TMR_W-1:0] timer_reg;
   logic [NCH-1:0]   trig_d_reg;
   logic [NCH-1:0]   pending_reg;
   logic [TS_W-1:0]  ts_reg [NCH];

   logic             start;
   logic             load;
   logic [NCH-1:0]   qual;
   logic [NCH-1:0]   hit;
   logic [NCH-1:0]   grant;
   logic [NCH-1:0]   grant_eff;
   logic [NCH-1:0]   take;
   logic [NCH-1:0]   drop;
   logic [CH_W-1:0]  grant_idx;
   logic             any;

   assign start     = (state_reg == IDLE) && run;
   assign load      = !stream.out_valid || stream.out_ready;
   assign grant_eff = grant & {NCH{load}};
   // A capture on a channel being granted this cycle refills it rather than dropping.
   assign take      = hit & (~pending_reg | grant_eff);
   assign drop      = hit & pending_reg & ~grant_eff;

`ifdef SELF_TRIG_PRESCALE_EN
   logic [7:0] prescale_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prescale_reg <= '0;
      else if (start) prescale_reg <= prescale;
   end
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         assign qual[gi] = (state_reg == RUN) && ch_trig[gi] && !trig_d_reg[gi]
                           && mask_reg[gi] && ch_ready[gi];
`ifdef SELF_TRIG_PRESCALE_EN
         logic [7:0] pcnt_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) pcnt_reg <= '0;
            else if (start) pcnt_reg <= '0;
            else if (qual[gi]) pcnt_reg <= (pcnt_reg == prescale_reg) ? '0 : pcnt_reg + 8'd1;
         end

         assign hit[gi] = qual[gi] && (pcnt_reg == prescale_reg);
`else
         assign hit[gi] = qual[gi];
`endif
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) ts_reg[gi] <= '0;
            else if (take[gi]) ts_reg[gi] <= ch_ts[gi*TS_W +: TS_W];
         end
      end
   endgenerate

   rr_arbiter #(.NCH(NCH), .IDX_W(CH_W)) u_rr (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (pending_reg),
      .advance   (load),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any       (any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_d_reg  <= '0;
         pending_reg <= '0;
      end else begin
         trig_d_reg  <= ch_trig;
         pending_reg <= (pending_reg & ~grant_eff) | hit;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stream.out_valid <= 1'b0;
         stream.out_chan  <= '0;
         stream.out_ts    <= '0;
      end else if (load) begin
         stream.out_valid <= any;
         if (any) begin
            stream.out_chan <= grant_idx;
            stream.out_ts   <= ts_reg[grant_idx];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_flags <= '0;
         ovf_cnt   <= '0;
      end else if (start) begin
         ovf_flags <= '0;
         ovf_cnt   <= '0;
      end else begin
         ovf_flags <= ovf_flags | drop;
         if (|drop && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         mask_reg  <= '0;
         timer_reg <= '0;
         ch_enable <= '0;
         armed     <= 1'b0;
         arm_err   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               ch_enable <= '0;
               armed     <= 1'b0;
               if (run) begin
                  mask_reg  <= ch_mask;
                  ch_enable <= ch_mask;
                  arm_err   <= 1'b0;
                  timer_reg <= TMR_W'(ARM_TIMEOUT);
                  state_reg <= ARM;
               end
            end
            ARM: begin
               if ((ch_ready & mask_reg) == mask_reg) begin
                  armed     <= 1'b1;
                  state_reg <= RUN;
               end else if (!run) begin
                  ch_enable <= '0;
                  state_reg <= IDLE;
               end else if (timer_reg == '0) begin
                  arm_err   <= 1'b1;
                  ch_enable <= '0;
                  state_reg <= IDLE;
               end else begin
                  timer_reg <= timer_reg - TMR_W'(1);
               end
            end
            RUN: begin
               if (!run) begin
                  armed     <= 1'b0;
                  ch_enable <= '0;
                  state_reg <= DRAIN;
               end
            end
            DRAIN: begin
               if (pending_reg == '0 && load) state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_self_trig_arbiter.sv
// Scoreboard bench for self_trig_arbiter: expected records are queued as edges are driven
// and compared when the output stream handshakes.
module tb_self_trig_arbiter;
   import self_trig_pkg::*;

   localparam int NCH  = 4;
   localparam int TS_W = 42;
   localparam int CH_W = 2;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                run;
   logic [NCH-1:0]      ch_mask;
   logic [NCH-1:0]      ch_enable;
   logic [NCH-1:0]      ch_ready;
   logic [NCH-1:0]      ch_trig;
   logic [NCH*TS_W-1:0] ch_ts;
   logic                armed;
   logic                arm_err;
   logic [NCH-1:0]      ovf_flags;
   logic [15:0]         ovf_cnt;
`ifdef SELF_TRIG_PRESCALE_EN
   logic [7:0]          prescale;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   rec_t exp_q[$];

   self_trig_arbiter_if #(.TS_W(TS_W), .CH_W(CH_W)) sif ();

   self_trig_arbiter #(.NCH(NCH), .TS_W(TS_W), .CH_W(CH_W), .ARM_TIMEOUT(255)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
      .ch_mask   (ch_mask),
      .ch_enable (ch_enable),
      .ch_ready  (ch_ready),
      .ch_trig   (ch_trig),
      .ch_ts     (ch_ts),
`ifdef SELF_TRIG_PRESCALE_EN
      .prescale  (prescale),
`endif
      .stream    (sif.master),
      .armed     (armed),
      .arm_err   (arm_err),
      .ovf_flags (ovf_flags),
      .ovf_cnt   (ovf_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic rec_t mk(input int c, input logic [TS_W-1:0] v);
      rec_t r;
      r.chan = c[CH_W-1:0];
      r.ts   = v;
      return r;
   endfunction

   // Monitor: inputs are driven on negedge, so #1 later the pending handshake is settled.
   always @(negedge clk) begin
      #1;
      if (rst_n && sif.out_valid && sif.out_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_extra", 64'd1, 64'd0);
         end else begin
            rec_t e;
            e = exp_q.pop_front();
            $display("rec chan=%0d ts=%0d (exp chan=%0d ts=%0d)", sif.out_chan, sif.out_ts, e.chan, e.ts);
            check("rec_chan", 64'(sif.out_chan), 64'(e.chan));
            check("rec_ts", 64'(sif.out_ts), 64'(e.ts));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_ts(input int ch, input logic [TS_W-1:0] v);
      ch_ts[ch*TS_W +: TS_W] = v;
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      run           = 1'b0;
      ch_mask       = '0;
      ch_ready      = '0;
      ch_trig       = '0;
      ch_ts         = '0;
      sif.out_ready = 1'b0;
`ifdef SELF_TRIG_PRESCALE_EN
      prescale      = 8'd0;
`endif
      exp_q.delete();
      tick(2);
      rst_n = 1'b1;
   endtask

   task automatic arm(input logic [NCH-1:0] m);
      bit ok;
      ok       = 1'b0;
      ch_mask  = m;
      ch_ready = '1;
      run      = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = armed;
      end
      check("arm_wait", 64'(armed), 64'd1);
   endtask

   task automatic pulse(input logic [NCH-1:0] m);
      ch_trig = m;
      @(negedge clk);
      ch_trig = '0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int first;

      // Reset state
      rst_n = 1'b0;
      do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_enable", 64'(ch_enable), 64'd0);
      check("rst_armed", 64'(armed), 64'd0);
      check("rst_err", 64'(arm_err), 64'd0);
      check("rst_valid", 64'(sif.out_valid), 64'd0);
      check("rst_ovf_flags", 64'(ovf_flags), 64'd0);
      check("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);

      // Arming with staggered ready
      do_reset();
      ch_mask = 4'b0101;
      run     = 1'b1;
      first   = -1;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         @(negedge clk);
         if (armed && first < 0) first = cyc;
         if (cyc == 3) ch_ready[0] = 1'b1;
         if (cyc == 7) ch_ready[2] = 1'b1;
      end
      check("arm_cycle", 64'(first), 64'd8);
      check("arm_enable", 64'(ch_enable), 64'b0101);
      check("arm_noerr", 64'(arm_err), 64'd0);

      // Arming timeout
      do_reset();
      ch_mask  = 4'b0011;
      ch_ready = 4'b0001;
      run      = 1'b1;
      first    = -1;
      for (int cyc = 1; cyc <= 400 && first < 0; cyc++) begin
         @(negedge clk);
         if (arm_err) begin
            first = cyc;
            run   = 1'b0;
         end
      end
      check("timeout_cycle", 64'(first), 64'd257);
      check("timeout_enable", 64'(ch_enable), 64'd0);
      tick(3);
      check("timeout_sticky", 64'(arm_err), 64'd1);
      check("timeout_armed", 64'(armed), 64'd0);

      // Simultaneous edges on all channels, then a round-robin wrap
      do_reset();
      for (int c = 0; c < NCH; c++) set_ts(c, TS_W'(100 + c));
      sif.out_ready = 1'b1;
      arm(4'b1111);
      for (int c = 0; c < NCH; c++) exp_q.push_back(mk(c, TS_W'(100 + c)));
      ch_trig = 4'b1111;
      @(negedge clk);
      check("lat_edge1", 64'(sif.out_valid), 64'd0);
      ch_trig = '0;
      @(negedge clk);
      check("lat_edge2", 64'(sif.out_valid), 64'd1);
      tick(4);
      check("burst_end_valid", 64'(sif.out_valid), 64'd0);
      check("burst_sb_empty", 64'(exp_q.size()), 64'd0);

      sif.out_ready = 1'b0;
      set_ts(2, TS_W'(220));
      exp_q.push_back(mk(2, TS_W'(220)));
      pulse(4'b0100);
      set_ts(1, TS_W'(210));
      set_ts(3, TS_W'(230));
      exp_q.push_back(mk(3, TS_W'(230)));
      exp_q.push_back(mk(1, TS_W'(210)));
      pulse(4'b1010);
      tick(1);
      sif.out_ready = 1'b1;
      tick(5);
      check("wrap_sb_empty", 64'(exp_q.size()), 64'd0);

      // Backpressure and drop
      do_reset();
      arm(4'b0011);
      set_ts(0, TS_W'(300));
      exp_q.push_back(mk(0, TS_W'(300)));
      pulse(4'b0001);
      set_ts(1, TS_W'(500));
      exp_q.push_back(mk(1, TS_W'(500)));
      pulse(4'b0010);
      set_ts(1, TS_W'(600));
      pulse(4'b0010);
      tick(1);
      check("bp_hold_valid", 64'(sif.out_valid), 64'd1);
      check("bp_hold_chan", 64'(sif.out_chan), 64'd0);
      check("bp_ovf_flags", 64'(ovf_flags), 64'b0010);
      check("bp_ovf_cnt", 64'(ovf_cnt), 64'd1);
      sif.out_ready = 1'b1;
      tick(4);
      check("bp_sb_empty", 64'(exp_q.size()), 64'd0);
      check("bp_ovf_cnt_after", 64'(ovf_cnt), 64'd1);

      // Drain with records outstanding
      do_reset();
      arm(4'b0101);
      set_ts(0, TS_W'(7));
      set_ts(2, TS_W'(9));
      exp_q.push_back(mk(0, TS_W'(7)));
      exp_q.push_back(mk(2, TS_W'(9)));
      pulse(4'b0101);
      tick(1);
      run = 1'b0;
      @(negedge clk);
      check("drain_enable", 64'(ch_enable), 64'd0);
      check("drain_armed", 64'(armed), 64'd0);
      set_ts(0, TS_W'(77));
      pulse(4'b0001);
      sif.out_ready = 1'b1;
      tick(5);
      check("drain_sb_empty", 64'(exp_q.size()), 64'd0);
      check("drain_valid", 64'(sif.out_valid), 64'd0);
      check("drain_no_drop", 64'(ovf_flags), 64'd0);
      run = 1'b1;
      @(negedge clk);
      check("drain_to_idle", 64'(ch_enable), 64'b0101);

`ifdef SELF_TRIG_PRESCALE_EN
      // Prescale: every third edge captured
      do_reset();
      prescale      = 8'd2;
      sif.out_ready = 1'b1;
      arm(4'b0001);
      for (int e = 1; e <= 9; e++) begin
         set_ts(0, TS_W'(1000 + e));
         if (e % 3 == 0) exp_q.push_back(mk(0, TS_W'(1000 + e)));
         pulse(4'b0001);
      end
      tick(4);
      check("presc_sb_empty", 64'(exp_q.size()), 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
